// File: rtl/writeback_merge_queue.sv
// Writeback merge queue: collects up to NUM_IN writeback results per cycle into
// a circular buffer in lane order, and drains up to NUM_OUT results per cycle
// onto registered broadcast lanes. Also provides input backpressure, consumer
// gating, a synchronous flush, an occupancy count and a sticky overflow flag.
module writeback_merge_queue #(
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 1,
    parameter int DEPTH   = 32,
    parameter int VREG_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_IN-1:0]          in_en,
    input  logic [NUM_IN*VREG_W-1:0]   in_vregid,
    input  logic [NUM_IN*DATA_W-1:0]   in_val,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic [NUM_OUT-1:0]         out_en,
    output logic [NUM_OUT*VREG_W-1:0]  out_vregid,
    output logic [NUM_OUT*DATA_W-1:0]  out_val,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Number of enabled lanes in a lane mask.
    function automatic logic [CW-1:0] popcount(input logic [NUM_IN-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Storage (no reset needed: only slots between head and tail are ever read)
    logic [VREG_W-1:0] vreg_mem [DEPTH];
    logic [DATA_W-1:0] val_mem  [DEPTH];

    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [NUM_OUT-1:0]        out_en_q, out_en_d;
    logic [NUM_OUT*VREG_W-1:0] out_vregid_q, out_vregid_d;
    logic [NUM_OUT*DATA_W-1:0] out_val_q, out_val_d;

    logic                      push_ok_s;
    logic                      pop_ok_s;
    logic [CW-1:0]             push_cnt_s;
    logic [CW-1:0]             pop_cnt_s;
    logic [PW-1:0]             wr_run_s;
    logic [PW-1:0]             wr_idx_s [NUM_IN];

    // Conservative full check: refuse unless a full NUM_IN-wide push fits.
    assign in_ready   = (count_q <= CW'(DEPTH - NUM_IN));
    assign out_en     = out_en_q;
    assign out_vregid = out_vregid_q;
    assign out_val    = out_val_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

    // Push/pop amounts and compacted write slots for the enabled lanes.
    always_comb begin
        push_ok_s = in_ready && !flush;
        pop_ok_s  = out_ready && !flush;
        if (push_ok_s) begin
            push_cnt_s = popcount(in_en);
        end else begin
            push_cnt_s = '0;
        end
        if (pop_ok_s) begin
            pop_cnt_s = (count_q < CW'(NUM_OUT)) ? count_q : CW'(NUM_OUT);
        end else begin
            pop_cnt_s = '0;
        end
        wr_run_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wr_idx_s[i] = tail_q + wr_run_s;
            if (in_en[i]) begin
                wr_run_s = wr_run_s + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_run_s = wr_run_s;
            end
        end
    end

    // Next-state for pointers, occupancy, overflow and the broadcast lanes.
    always_comb begin
        out_en_d     = '0;
        out_vregid_d = out_vregid_q;
        out_val_d    = out_val_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            head_d  = head_q + pop_cnt_s[PW-1:0];
            tail_d  = tail_q + push_cnt_s[PW-1:0];
            count_d = count_q + push_cnt_s - pop_cnt_s;
            if (!in_ready && (|in_en)) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (CW'(k) < pop_cnt_s) begin
                out_en_d[k]                       = 1'b1;
                out_vregid_d[k*VREG_W +: VREG_W]  = vreg_mem[head_q + PW'(k)];
                out_val_d[k*DATA_W +: DATA_W]     = val_mem[head_q + PW'(k)];
            end else begin
                out_en_d[k] = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            out_en_q     <= '0;
            out_vregid_q <= '0;
            out_val_q    <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            out_en_q     <= out_en_d;
            out_vregid_q <= out_vregid_d;
            out_val_q    <= out_val_d;
        end
    end

    // Storage writes: enabled lanes land in consecutive slots from tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (push_ok_s && in_en[i]) begin
                vreg_mem[wr_idx_s[i]] <= in_vregid[i*VREG_W +: VREG_W];
                val_mem[wr_idx_s[i]]  <= in_val[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
